// File: rtl/cubic_pkg.sv
// Shared constants and FSM encoding for the cubic-convolution interpolator.
package cubic_pkg;

    localparam int Q16_ONE       = 65536;
    localparam int Q16_TWO       = 131072;
    localparam int K_LAT_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/tap_tag_delay.sv
// Delay line carrying {valid, tap index} alongside each distance sent to the kernel pipeline.
module tap_tag_delay #(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_idx,
    output logic       out_valid,
    output logic [1:0] out_idx,
    output logic       busy
);

    logic [DEPTH-1:0] vld_r;
    logic [1:0]       idx_r [DEPTH];

    // Shift tags one stage per cycle; reset drops every tag in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_r[i] <= 2'd0;
            end
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                idx_r[i] <= idx_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_idx   = idx_r[DEPTH-1];
    assign busy      = |vld_r;

endmodule

// File: rtl/cubic_interp_1d.sv
// Cubic-convolution interpolator: issues four tap distances to the kernel pipeline,
// accumulates the returned weights against four samples, rounds and saturates.
module cubic_interp_1d
    import cubic_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int R_WIDTH  = 18,
    parameter int K_LAT    = K_LAT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [15:0]                s_frac_q16,
    input  logic signed [SAMPLE_W-1:0] s_p0,
    input  logic signed [SAMPLE_W-1:0] s_p1,
    input  logic signed [SAMPLE_W-1:0] s_p2,
    input  logic signed [SAMPLE_W-1:0] s_p3,
    output logic [R_WIDTH-1:0]         k_r_q16,
    input  logic signed [31:0]         k_w_q16,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [SAMPLE_W-1:0] m_y
);

    localparam logic signed [33:0] Y_MAX = 34'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [33:0] Y_MIN = ~Y_MAX;

    state_t                      state_r, state_s;
    logic [1:0]                  tap_cnt_r;
    logic [15:0]                 t_r;
    logic signed [SAMPLE_W-1:0]  p_r [4];
    logic signed [49:0]          acc_r;
    logic [R_WIDTH-1:0]          k_r_r;
    logic                        m_valid_r;
    logic signed [SAMPLE_W-1:0]  m_y_r;
    logic                        accept_s, finish_s, done_s;
    logic                        tag_vld_s, tag_busy_s;
    logic [1:0]                  tag_idx_s;
    logic signed [47:0]          prod_s;
    logic signed [33:0]          y_full_s;
    logic signed [SAMPLE_W-1:0]  y_sat_s;

    // Tap distances: d0=1+t, d1=t, d2=1-t, d3=2-t in unsigned Q16
    function automatic logic [R_WIDTH-1:0] tap_dist(input logic [1:0] idx, input logic [15:0] t);
        logic [R_WIDTH-1:0] tw;
        tw = R_WIDTH'(t);
        case (idx)
            2'd0:    tap_dist = R_WIDTH'(Q16_ONE) + tw;
            2'd1:    tap_dist = tw;
            2'd2:    tap_dist = R_WIDTH'(Q16_ONE) - tw;
            2'd3:    tap_dist = R_WIDTH'(Q16_TWO) - tw;
            default: tap_dist = {R_WIDTH{1'b0}};
        endcase
    endfunction

    tap_tag_delay #(.DEPTH(K_LAT)) u_tag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_r == ISSUE),
        .in_idx    (tap_cnt_r),
        .out_valid (tag_vld_s),
        .out_idx   (tag_idx_s),
        .busy      (tag_busy_s)
    );

    assign s_ready = (state_r == IDLE) && !rst;
    assign prod_s  = k_w_q16 * p_r[tag_idx_s];
    assign y_full_s = 34'((acc_r + 50'sd32768) >>> 16);

    // Next-state and handshake strobes
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_valid && !rst) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                if (tap_cnt_r == 2'd3) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            // An empty tag pipe means the last weight has already been summed
            WAIT: begin
                if (!tag_busy_s) begin
                    finish_s = 1'b1;
                    state_s  = OUT;
                end else begin
                    state_s  = WAIT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Clamp the rounded accumulator into the signed sample range
    always_comb begin
        y_sat_s = {SAMPLE_W{1'b0}};
        if (y_full_s > Y_MAX) begin
            y_sat_s = Y_MAX[SAMPLE_W-1:0];
        end else if (y_full_s < Y_MIN) begin
            y_sat_s = Y_MIN[SAMPLE_W-1:0];
        end else begin
            y_sat_s = y_full_s[SAMPLE_W-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, distance issue, MAC and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_r <= 2'd0;
            t_r       <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                p_r[i] <= {SAMPLE_W{1'b0}};
            end
            acc_r     <= 50'sd0;
            k_r_r     <= {R_WIDTH{1'b0}};
            m_valid_r <= 1'b0;
            m_y_r     <= {SAMPLE_W{1'b0}};
        end else begin
            if (accept_s) begin
                t_r       <= s_frac_q16;
                p_r[0]    <= s_p0;
                p_r[1]    <= s_p1;
                p_r[2]    <= s_p2;
                p_r[3]    <= s_p3;
                tap_cnt_r <= 2'd0;
                k_r_r     <= tap_dist(2'd0, s_frac_q16);
            end else if (state_r == ISSUE) begin
                tap_cnt_r <= tap_cnt_r + 2'd1;
                k_r_r     <= (tap_cnt_r == 2'd3) ? {R_WIDTH{1'b0}} : tap_dist(tap_cnt_r + 2'd1, t_r);
            end else begin
                k_r_r     <= {R_WIDTH{1'b0}};
            end

            if (accept_s) begin
                acc_r <= 50'sd0;
            end else if (tag_vld_s) begin
                acc_r <= acc_r + 50'(prod_s);
            end

            if (finish_s) begin
                m_valid_r <= 1'b1;
                m_y_r     <= y_sat_s;
            end else if (done_s) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign k_r_q16 = k_r_r;
    assign m_valid = m_valid_r;
    assign m_y     = m_y_r;

endmodule

// File: tb/tb_cubic_interp_1d.sv
// Scoreboard bench for cubic_interp_1d with a stub kernel pipeline and an arithmetic reference model.
module tb_cubic_interp_1d;
    import cubic_pkg::*;

    localparam int SW = 16;
    localparam int RW = 18;
    localparam int KL = K_LAT_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_frac_q16;
    logic signed [SW-1:0] s_p0, s_p1, s_p2, s_p3, m_y;
    logic [RW-1:0] k_r_q16;
    logic signed [31:0] k_w_q16;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int stub_mode = 0;
    logic [RW-1:0] stub_tgt = '0;
    int rdy_mode = 1;
    logic [RW-1:0] r_hist [KL] = '{default: '0};

    cubic_interp_1d #(.SAMPLE_W(SW), .R_WIDTH(RW), .K_LAT(KL)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_frac_q16(s_frac_q16),
        .s_p0(s_p0), .s_p1(s_p1), .s_p2(s_p2), .s_p3(s_p3), .k_r_q16(k_r_q16), .k_w_q16(k_w_q16),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y)
    );

    always #5 clk = ~clk;

    // Stub kernel weight as a function of the distance it was given
    function automatic logic signed [31:0] wfun(input logic [RW-1:0] r, input int mode, input logic [RW-1:0] tgt);
        longint v;
        case (mode)
            0: v = 16384;
            1: v = (r == 0) ? 65536 : 0;
            2: v = (r == tgt) ? 32768 : 0;
            3: v = 65536;
            default: v = ((longint'(r) * 40503) % 262144) - 131072;
        endcase
        return 32'(v);
    endfunction

    // Reference: y = sat(floor((sum w(d_n)*p_n + 0.5)))
    function automatic int model_y(input int t, input int p [4], input int mode, input logic [RW-1:0] tgt);
        longint d [4];
        longint sum, y;
        d[0] = 65536 + t; d[1] = t; d[2] = 65536 - t; d[3] = 131072 - t;
        sum = 0;
        for (int n = 0; n < 4; n++) sum += longint'(wfun(RW'(d[n]), mode, tgt)) * p[n];
        y = (sum + 32768) >>> 16;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Kernel pipeline stub: weight for a distance appears KL cycles later
    always @(posedge clk) begin
        r_hist[0] <= k_r_q16;
        for (int i = 1; i < KL; i++) r_hist[i] <= r_hist[i-1];
    end
    assign k_w_q16 = wfun(r_hist[KL-1], stub_mode, stub_tgt);

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: every output handshake pops one expected value
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_out: got %0d with no request outstanding", m_y);
                end else begin
                    chk("m_y", m_y, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int t, input int p [4], output int waited);
        bit rdy, ok;
        s_frac_q16 = 16'(t);
        s_p0 = 16'(p[0]); s_p1 = 16'(p[1]); s_p2 = 16'(p[2]); s_p3 = 16'(p[3]);
        s_valid = 1'b1;
        waited = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            waited++;
            if (rdy) begin
                exp_q.push_back(model_y(t, p, stub_mode, stub_tgt));
                ok = 1'b1;
                break;
            end
        end
        #1;
        s_valid = 1'b0;
        s_frac_q16 = 16'($urandom);
        s_p0 = 16'($urandom); s_p1 = 16'($urandom); s_p2 = 16'($urandom); s_p3 = 16'($urandom);
        chk("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && s_ready) break;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pv [4];
        int w, lat, y_exp, seen;
        int kexp [5];
        s_valid = 1'b0; s_frac_q16 = 16'd0;
        s_p0 = '0; s_p1 = '0; s_p2 = '0; s_p3 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_k_r", k_r_q16, 0);
        chk("rst_m_y", m_y, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);
        @(posedge clk); #1;

        // Quarter weights, latency to first m_valid
        stub_mode = 0; rdy_mode = 1;
        pv = '{100, 200, 300, 400};
        send(0, pv, w);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (m_valid) begin lat = i; break; end
        end
        chk("latency", lat, KL + 6);
        wait_idle(100);

        // Tap-1 selector and distance sequence
        stub_mode = 1;
        pv = '{-7, 1234, 5, 9};
        kexp = '{65536, 0, 65536, 131072, 0};
        send(0, pv, w);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("k_r_seq", k_r_q16, kexp[n]);
        end
        wait_idle(100);

        // Round-half-up on +1.5 and -1.5
        stub_mode = 2; stub_tgt = 18'd16384;
        pv = '{$urandom_range(0, 999), 3, $urandom_range(0, 999), -50};
        send(16384, pv, w);
        wait_idle(100);
        pv[1] = -3;
        send(16384, pv, w);
        wait_idle(100);

        // Saturation both ways
        stub_mode = 3;
        pv = '{30000, 30000, 30000, 30000};
        send($urandom_range(0, 65535), pv, w);
        wait_idle(100);
        pv = '{-30000, -30000, -30000, -30000};
        send($urandom_range(0, 65535), pv, w);
        wait_idle(100);

        // Backpressure: output held, pending request refused
        stub_mode = 0; rdy_mode = 0;
        pv = '{$urandom_range(0, 4000) - 2000, 77, -300, 1200};
        y_exp = model_y(1000, pv, 0, stub_tgt);
        send(1000, pv, w);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_valid) begin seen = 1; break; end
        end
        chk("bp_valid_seen", seen, 1);
        @(posedge clk); #1;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_m_y_stable", m_y, y_exp);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        pv = '{10, 20, 30, 40};
        send(500, pv, w);
        chk("accept_after_hs", w, 2);
        wait_idle(100);

        // Reset in T+7 of a request
        pv = '{1000, 2000, 3000, 4000};
        send(0, pv, w);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_m_valid", m_valid, 0);
        chk("rst_mid_k_r", k_r_q16, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_s_ready", s_ready, 1);
        @(posedge clk); #1;
        pv = '{100, 200, 300, 400};
        send(0, pv, w);
        wait_idle(100);

        // Randomized traffic with random backpressure
        stub_mode = 4; rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (k % 2 == 0) pv[n] = int'($urandom_range(0, 65535)) - 32768;
                else pv[n] = int'($urandom_range(0, 4000)) - 2000;
            end
            send($urandom_range(0, 65535), pv, w);
        end
        wait_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
